control_sequencer: RTL

Multicycle fetch/decode/execute controller for the 16-bit accumulator machine. It owns the architectural registers PC, ACC, MAR, MBR and IR. It drives the main-memory port (synchronous, 1-cycle read latency) and the combinational ALU, and sequences each instruction through a fixed state machine. It sits directly upstream of the ALU and main memory, and replaces the bare register instances in the top level.

---
 rtl/control_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multicycle fetch/decode/execute controller for the 16-bit accumulator machine.
// Owns PC, ACC, MAR, MBR and IR, and drives the memory port and ALU operand/opcode lines.
module control_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic [15:0] pc,
    output logic [15:0] acc,
    output logic [15:0] ir,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ST_F0 = 4'd0,
        ST_F1 = 4'd1,
        ST_F2 = 4'd2,
        ST_DE = 4'd3,
        ST_R1 = 4'd4,
        ST_R2 = 4'd5,
        ST_EX = 4'd6,
        ST_WR = 4'd7,
        ST_HL = 4'd8
    } state_t;

    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_AND      = 4'h5;
    localparam logic [3:0] OP_OR       = 4'h6;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;
    localparam logic [3:0] OP_CLEAR    = 4'hA;
    localparam logic [3:0] OP_JUMPI    = 4'hB;
    localparam logic [3:0] OP_SHL      = 4'hC;
    localparam logic [3:0] OP_SHR      = 4'hD;

    // ALU opcode presented for a given instruction opcode; non-ALU ops present 0000.
    function automatic logic [3:0] alu_op_for(input logic [3:0] op);
        logic [3:0] sel;
        case (op)
            OP_ADD:  sel = 4'b0000;
            OP_SUBT: sel = 4'b0001;
            OP_AND:  sel = 4'b1000;
            OP_OR:   sel = 4'b1001;
            OP_SHL:  sel = 4'b0100;
            OP_SHR:  sel = 4'b0101;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic skip_taken(input logic [1:0] cond, input logic [15:0] a);
        logic take;
        case (cond)
            2'b00:   take = a[15];
            2'b01:   take = (a == 16'h0000);
            2'b10:   take = (a != 16'h0000) && !a[15];
            default: take = 1'b0;
        endcase
        return take;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic [15:0] acc_r, acc_s;
    logic [15:0] mar_r, mar_s;
    logic [15:0] mbr_r, mbr_s;
    logic [15:0] ir_r, ir_s;
    logic        halted_r, halted_s;
    logic        illegal_r, illegal_s;
    logic        done_s;
    logic        we_s;
    logic [3:0]  alu_sel_s;
    logic [3:0]  opcode_s;
    logic [15:0] addr_x_s;

    assign opcode_s = ir_r[15:12];
    assign addr_x_s = {4'h0, ir_r[11:0]};

    // Next-state and datapath update logic for the instruction sequencer.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        acc_s     = acc_r;
        mar_s     = mar_r;
        mbr_s     = mbr_r;
        ir_s      = ir_r;
        halted_s  = halted_r;
        illegal_s = illegal_r;
        done_s    = 1'b0;
        we_s      = 1'b0;
        alu_sel_s = 4'b0000;
        case (state_r)
            ST_F0: begin
                mar_s   = pc_r;
                state_s = ST_F1;
            end
            ST_F1: begin
                state_s = ST_F2;
            end
            ST_F2: begin
                ir_s    = mem_rdata;
                pc_s    = pc_r + 16'd1;
                state_s = ST_DE;
            end
            ST_DE: begin
                alu_sel_s = alu_op_for(opcode_s);
                case (opcode_s)
                    OP_LOAD, OP_ADD, OP_SUBT, OP_AND, OP_OR, OP_JUMPI: begin
                        mar_s   = addr_x_s;
                        state_s = ST_R1;
                    end
                    OP_STORE: begin
                        mar_s   = addr_x_s;
                        state_s = ST_WR;
                    end
                    OP_JUMP: begin
                        pc_s    = addr_x_s;
                        done_s  = 1'b1;
                        state_s = ST_F0;
                    end
                    OP_CLEAR: begin
                        acc_s   = 16'h0000;
                        done_s  = 1'b1;
                        state_s = ST_F0;
                    end
                    OP_SHL, OP_SHR: begin
                        acc_s   = alu_result;
                        done_s  = 1'b1;
                        state_s = ST_F0;
                    end
                    OP_SKIPCOND: begin
                        if (skip_taken(ir_r[11:10], acc_r)) begin
                            pc_s = pc_r + 16'd1;
                        end else begin
                            pc_s = pc_r;
                        end
                        done_s  = 1'b1;
                        state_s = ST_F0;
                    end
                    OP_HALT: begin
                        halted_s = 1'b1;
                        done_s   = 1'b1;
                        state_s  = ST_HL;
                    end
                    default: begin
                        // Opcodes 0, E, F: stop without retiring the instruction.
                        halted_s  = 1'b1;
                        illegal_s = 1'b1;
                        state_s   = ST_HL;
                    end
                endcase
            end
            ST_R1: begin
                state_s = ST_R2;
            end
            ST_R2: begin
                mbr_s   = mem_rdata;
                state_s = ST_EX;
            end
            ST_EX: begin
                alu_sel_s = alu_op_for(opcode_s);
                case (opcode_s)
                    OP_LOAD:                         acc_s = mbr_r;
                    OP_ADD, OP_SUBT, OP_AND, OP_OR:  acc_s = alu_result;
                    OP_JUMPI:                        pc_s  = mbr_r;
                    default:                         acc_s = acc_r;
                endcase
                done_s  = 1'b1;
                state_s = ST_F0;
            end
            ST_WR: begin
                we_s    = 1'b1;
                done_s  = 1'b1;
                state_s = ST_F0;
            end
            ST_HL: begin
                state_s = ST_HL;
            end
            default: begin
                // A corrupted state encoding is treated as a fatal fault: park in HL.
                halted_s  = 1'b1;
                illegal_s = 1'b1;
                state_s   = ST_HL;
            end
        endcase
    end

    // Architectural and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_F0;
            pc_r      <= RESET_PC;
            acc_r     <= 16'h0000;
            mar_r     <= 16'h0000;
            mbr_r     <= 16'h0000;
            ir_r      <= 16'h0000;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            acc_r     <= acc_s;
            mar_r     <= mar_s;
            mbr_r     <= mbr_s;
            ir_r      <= ir_s;
            halted_r  <= halted_s;
            illegal_r <= illegal_s;
        end
    end

    // Reset gates the strobes so a reset landing in WR never writes memory.
    assign mem_we     = we_s & ~reset;
    assign instr_done = done_s & ~reset;
    assign alu_op     = alu_sel_s;
    assign mem_addr   = mar_r;
    assign mem_wdata  = acc_r;
    assign alu_a      = acc_r;
    assign alu_b      = mbr_r;
    assign pc         = pc_r;
    assign acc        = acc_r;
    assign ir         = ir_r;
    assign halted     = halted_r;
    assign illegal    = illegal_r;

endmodule
